// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared state encoding for the instruction-fetch sequencer
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2,
        FS_REDIR = 2'd3
    } fs_state_t;

endpackage

// File: rtl/fetch_seq.sv
// fetch_seq: fetches one instruction per handshake at pc, latches it into ir, and steers the PC
import fetch_seq_pkg::*;

module fetch_seq #(
    parameter int WIDTH = 32,
    parameter int IW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_load_val,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [IW-1:0]    mem_rdata,
    output logic [IW-1:0]    ir,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             br_req,
    input  logic [WIDTH-1:0] br_target
);

    fs_state_t        state;
    logic [WIDTH-1:0] tgt;
    logic             br_pend;

    // Sequencer: every state captures a redirect target; a redirect seen mid-fetch waits for the ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FS_IDLE;
            ir       <= '0;
            ir_valid <= 1'b0;
            tgt      <= '0;
            br_pend  <= 1'b0;
        end else begin
            if (br_req)
                tgt <= br_target;
            case (state)
                FS_IDLE:
                    state <= br_req ? FS_REDIR : FS_FETCH;
                FS_FETCH:
                    if (mem_ack) begin
                        if (br_pend || br_req) begin
                            state <= FS_REDIR;
                        end else begin
                            ir       <= mem_rdata;
                            ir_valid <= 1'b1;
                            state    <= FS_HOLD;
                        end
                    end else if (br_req) begin
                        br_pend <= 1'b1;
                    end
                FS_HOLD:
                    if (br_req || ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= br_req ? FS_REDIR : FS_FETCH;
                    end
                FS_REDIR:
                    if (!br_req) begin
                        br_pend <= 1'b0;
                        state   <= FS_FETCH;
                    end
            endcase
        end
    end

    // Strobes decode from state so the PC increments in the very cycle the word returns
    always_comb begin
        mem_req     = state == FS_FETCH;
        mem_addr    = pc;
        pc_inc      = mem_req && mem_ack && !br_pend && !br_req;
        pc_load     = state == FS_REDIR;
        pc_load_val = tgt;
    end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed and randomized checks of fetch_seq against a PC register and memory model
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic        pc_inc, pc_load, mem_req, ir_valid;
    logic [31:0] pc_load_val, mem_addr, ir;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ir_ready = 1'b0;
    logic        br_req = 1'b0;
    logic [31:0] br_target = '0;

    int errs = 0;
    int nchk = 0;
    int wait_cfg = 0;
    int wcnt = 0;
    bit rand_wait = 1'b0;

    fetch_seq #(.WIDTH(32), .IW(32)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .br_req(br_req), .br_target(br_target)
    );

    always #5 clk = ~clk;

    // PC register beside the sequencer: increment has priority over load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= '0;
        else if (pc_inc) pc <= pc + 32'd1;
        else if (pc_load) pc <= pc_load_val;
    end

    assert property (@(posedge clk) disable iff (reset) !(pc_inc && pc_load))
        else begin errs++; $display("FAIL excl: pc_inc=1 and pc_load=1 together"); end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // One cycle: drive inputs after the falling edge, memory acks after wait_cfg waiting cycles
    task automatic cyc(input logic rdy, input logic br, input logic [31:0] tg);
        @(negedge clk);
        ir_ready  = rdy;
        br_req    = br;
        br_target = tg;
        mem_ack   = mem_req && wcnt >= wait_cfg;
        mem_rdata = mem_fn(mem_addr);
        wcnt      = (mem_ack || !mem_req) ? 0 : wcnt + 1;
        if (mem_ack && rand_wait) wait_cfg = $urandom_range(0, 3);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ir_ready = 1'b0; br_req = 1'b0; br_target = '0;
        mem_ack = 1'b0; mem_rdata = '0; wcnt = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        nchk++; if ({pc_inc, pc_load, mem_req} !== 3'b000) begin errs++; $display("FAIL rst_strobes: got %b want 000", {pc_inc, pc_load, mem_req}); end
        nchk++; if ({ir_valid, ir} !== 33'd0) begin errs++; $display("FAIL rst_ir: got v=%b ir=%h want 0/0", ir_valid, ir); end
        nchk++; if (pc_load_val !== 32'd0) begin errs++; $display("FAIL rst_ldval: got %h want 0", pc_load_val); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        nchk++; if (mem_req !== 1'b0) begin errs++; $display("FAIL idle_req: got %b want 0", mem_req); end
        wait_cfg = 100;
        cyc(1'b0, 1'b0, '0);
        nchk++; if ({mem_req, mem_addr} !== {1'b1, 32'd0}) begin errs++; $display("FAIL first_fetch: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        wait_cfg = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, '0);
            nchk++; if ({mem_req, mem_addr, pc_inc, ir_valid} !== {1'b1, 32'(k), 1'b1, 1'b0}) begin errs++; $display("FAIL zw_fetch%0d: got req=%b addr=%h inc=%b v=%b want 1/%h/1/0", k, mem_req, mem_addr, pc_inc, ir_valid, k); end
            cyc(1'b1, 1'b0, '0);
            nchk++; if ({mem_req, pc_inc, ir_valid, ir} !== {1'b0, 1'b0, 1'b1, mem_fn(32'(k))}) begin errs++; $display("FAIL zw_hold%0d: got req=%b inc=%b v=%b ir=%h want 0/0/1/%h", k, mem_req, pc_inc, ir_valid, ir, mem_fn(32'(k))); end
            nchk++; if (pc !== 32'(k + 1)) begin errs++; $display("FAIL zw_pc%0d: got %h want %h", k, pc, k + 1); end
        end
    endtask

    task automatic test_delay();
        do_reset();
        wait_cfg = 3;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, '0);
            nchk++; if ({mem_req, mem_addr, pc_inc, pc} !== {1'b1, 32'd0, i == 3, 32'd0}) begin errs++; $display("FAIL dly%0d: got req=%b addr=%h inc=%b pc=%h want 1/0/%0d/0", i, mem_req, mem_addr, pc_inc, pc, i == 3); end
        end
        cyc(1'b0, 1'b0, '0);
        nchk++; if ({ir_valid, ir, pc} !== {1'b1, mem_fn(0), 32'd1}) begin errs++; $display("FAIL dly_ir: got v=%b ir=%h pc=%h want 1/%h/1", ir_valid, ir, pc, mem_fn(0)); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, '0);
            nchk++; if ({ir_valid, ir, mem_req, pc_inc, pc} !== {1'b1, mem_fn(0), 1'b0, 1'b0, 32'd1}) begin errs++; $display("FAIL stall%0d: got v=%b ir=%h req=%b inc=%b pc=%h", i, ir_valid, ir, mem_req, pc_inc, pc); end
        end
        cyc(1'b1, 1'b0, '0);
        wait_cfg = 0;
        cyc(1'b1, 1'b0, '0);
        nchk++; if ({mem_req, mem_addr, ir_valid} !== {1'b1, 32'd1, 1'b0}) begin errs++; $display("FAIL stall_next: got req=%b addr=%h v=%b want 1/1/0", mem_req, mem_addr, ir_valid); end
    endtask

    task automatic test_branch_fetch();
        do_reset();
        wait_cfg = 3;
        cyc(1'b0, 1'b1, 32'h40);
        nchk++; if ({mem_req, pc_inc, pc_load} !== 3'b100) begin errs++; $display("FAIL brf_req: got req=%b inc=%b ld=%b want 1/0/0", mem_req, pc_inc, pc_load); end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, '0);
            nchk++; if ({mem_req, pc_inc, ir_valid} !== 3'b100) begin errs++; $display("FAIL brf_wait%0d: got req=%b inc=%b v=%b want 1/0/0", i, mem_req, pc_inc, ir_valid); end
        end
        cyc(1'b1, 1'b0, '0);
        nchk++; if ({pc_load, pc_load_val, pc_inc, ir_valid, mem_req} !== {1'b1, 32'h40, 3'b000}) begin errs++; $display("FAIL brf_redir: got ld=%b val=%h inc=%b v=%b req=%b want 1/40/0/0/0", pc_load, pc_load_val, pc_inc, ir_valid, mem_req); end
        wait_cfg = 0;
        cyc(1'b1, 1'b0, '0);
        nchk++; if ({mem_req, mem_addr, pc_load} !== {1'b1, 32'h40, 1'b0}) begin errs++; $display("FAIL brf_refetch: got req=%b addr=%h ld=%b want 1/40/0", mem_req, mem_addr, pc_load); end
    endtask

    task automatic test_double_branch();
        do_reset();
        wait_cfg = 0;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 32'h10);
        nchk++; if ({ir_valid, ir} !== {1'b1, mem_fn(0)}) begin errs++; $display("FAIL db_hold: got v=%b ir=%h want 1/%h", ir_valid, ir, mem_fn(0)); end
        cyc(1'b0, 1'b1, 32'h20);
        nchk++; if ({pc_load, pc_load_val, ir_valid} !== {1'b1, 32'h10, 1'b0}) begin errs++; $display("FAIL db_redir1: got ld=%b val=%h v=%b want 1/10/0", pc_load, pc_load_val, ir_valid); end
        cyc(1'b0, 1'b0, '0);
        nchk++; if ({pc_load, pc_load_val} !== {1'b1, 32'h20}) begin errs++; $display("FAIL db_redir2: got ld=%b val=%h want 1/20", pc_load, pc_load_val); end
        cyc(1'b1, 1'b0, '0);
        nchk++; if ({mem_req, mem_addr, pc_load} !== {1'b1, 32'h20, 1'b0}) begin errs++; $display("FAIL db_fetch: got req=%b addr=%h ld=%b want 1/20/0", mem_req, mem_addr, pc_load); end
        cyc(1'b1, 1'b0, '0);
        nchk++; if ({ir_valid, ir} !== {1'b1, mem_fn(32'h20)}) begin errs++; $display("FAIL db_ir: got v=%b ir=%h want 1/%h", ir_valid, ir, mem_fn(32'h20)); end
    endtask

    task automatic test_reset_mid();
        wait_cfg = 100;
        cyc(1'b0, 1'b0, '0);
        nchk++; if ({mem_req, mem_addr} !== {1'b1, 32'h21}) begin errs++; $display("FAIL rm_fetch: got req=%b addr=%h want 1/21", mem_req, mem_addr); end
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b0;
        #1;
        nchk++; if ({pc_inc, pc_load, mem_req, ir_valid} !== 4'b0000) begin errs++; $display("FAIL rm_strobes: got inc=%b ld=%b req=%b v=%b want 0", pc_inc, pc_load, mem_req, ir_valid); end
        nchk++; if ({ir, pc_load_val, pc} !== 96'd0) begin errs++; $display("FAIL rm_regs: got ir=%h val=%h pc=%h want 0", ir, pc_load_val, pc); end
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        wcnt = 0;
        #1;
        nchk++; if ({pc_inc, mem_req} !== 2'b00) begin errs++; $display("FAIL rm_late_ack: got inc=%b req=%b want 0/0", pc_inc, mem_req); end
        wait_cfg = 0;
        cyc(1'b1, 1'b0, '0);
        nchk++; if ({mem_req, mem_addr, ir_valid} !== {1'b1, 32'd0, 1'b0}) begin errs++; $display("FAIL rm_restart: got req=%b addr=%h v=%b want 1/0/0", mem_req, mem_addr, ir_valid); end
        cyc(1'b1, 1'b0, '0);
        nchk++; if ({ir_valid, ir} !== {1'b1, mem_fn(0)}) begin errs++; $display("FAIL rm_ir: got v=%b ir=%h want 1/%h", ir_valid, ir, mem_fn(0)); end
    endtask

    // Program-order model: accepted words follow +1 from the last accept or the most recent branch target
    task automatic test_random();
        logic [31:0] exp_next;
        logic        prev_req, prev_ack;
        int          accepts;
        do_reset();
        rand_wait = 1'b1;
        wait_cfg  = $urandom_range(0, 3);
        exp_next  = '0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        accepts   = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
            nchk++; if (pc_inc && pc_load) begin errs++; $display("FAIL rnd_excl@%0d: got inc=1 ld=1 want not both", n); end
            nchk++; if (pc_inc && !mem_ack) begin errs++; $display("FAIL rnd_inc@%0d: got inc=1 without ack want 0", n); end
            if (mem_req) begin
                nchk++; if (mem_addr !== pc) begin errs++; $display("FAIL rnd_addr@%0d: got %h want %h", n, mem_addr, pc); end
            end
            if (prev_req && !prev_ack) begin
                nchk++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rnd_hold_req@%0d: got %b want 1", n, mem_req); end
            end
            if (br_req) begin
                exp_next = br_target;
            end else if (ir_valid && ir_ready) begin
                nchk++; if (ir !== mem_fn(exp_next)) begin errs++; $display("FAIL rnd_ir@%0d: got %h want %h (addr %h)", n, ir, mem_fn(exp_next), exp_next); end
                exp_next++;
                accepts++;
            end
            prev_req = mem_req;
            prev_ack = mem_ack;
        end
        rand_wait = 1'b0;
        nchk++; if (accepts < 100) begin errs++; $display("FAIL rnd_progress: got %0d accepts want >= 100", accepts); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_delay();
        test_stall();
        test_branch_fetch();
        test_double_branch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
